pwr_req_ctrl: RTL and testbench

//  Upstream request stage for the power-control sequencer. Watches domain activity
//  and software/wake requests, runs a quiesce handshake with the domain, and drives
//  the level pwr_sig (1 = power down, 0 = power up) consumed by the sequencer.

---
 rtl/pwr_ctrl_pkg.sv | 14 +
 rtl/pwr_req_timer.sv | 29 ++
 rtl/pwr_req_ctrl.sv | 127 ++++++++++++
 tb/tb_pwr_req_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/pwr_ctrl_pkg.sv
// Shared types and constants for the power-request controller.
package pwr_ctrl_pkg;

  localparam int unsigned CNT_W = 8;

  typedef enum logic [2:0] {
    StRun     = 3'd0,
    StQuiesce = 3'd1,
    StDownSeq = 3'd2,
    StOff     = 3'd3,
    StUpSeq   = 3'd4
  } pd_state_e;

endpackage

// File: rtl/pwr_req_timer.sv
// Loadable saturating up-counter with a terminal (>=) compare.
module pwr_req_timer
  import pwr_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clr,
  input  logic             i_inc,
  input  logic [CNT_W-1:0] i_term,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_hit
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;
  assign o_hit = (r_cnt >= i_term);

endmodule

// File: rtl/pwr_req_ctrl.sv
// Power-request stage: idle/software power-down with quiesce handshake, held
// sequencer levels on pwr_sig, minimum off time and wake-driven power-up.
module pwr_req_ctrl
  import pwr_ctrl_pkg::*;
#(
  parameter int unsigned IDLE_CYCLES = 16,
  parameter int unsigned SEQ_CYCLES  = 3,
  parameter int unsigned MIN_OFF     = 8,
  parameter int unsigned ACK_TIMEOUT = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pd_en,
  input  logic       busy,
  input  logic       sw_pd_req,
  input  logic       wake_req,
  input  logic       quiesce_ack,
  output logic       pwr_sig,
  output logic       quiesce_req,
  output logic       domain_off,
  output logic       domain_on,
  output logic       abort,
  output logic [2:0] pd_state
);

  pd_state_e        r_state;
  pd_state_e        w_state_d;
  logic             r_pwr_sig;
  logic             r_quiesce_req;
  logic             r_domain_off;
  logic             r_domain_on;
  logic             r_abort;
  logic             w_abort;
  logic             w_clr;
  logic             w_inc;
  logic             w_hit;
  logic             w_idle;
  logic [CNT_W-1:0] w_term;
  logic [CNT_W-1:0] w_cnt;

  assign w_idle = pd_en & ~busy;

  pwr_req_timer u_timer (
    .clk    (clk),
    .reset  (reset),
    .i_clr  (w_clr),
    .i_inc  (w_inc),
    .i_term (w_term),
    .o_cnt  (w_cnt),
    .o_hit  (w_hit)
  );

  always_comb begin
    w_state_d = r_state;
    w_inc     = 1'b1;
    w_clr     = 1'b0;
    w_term    = '0;
    w_abort   = 1'b0;
    unique case (r_state)
      StRun: begin
        w_term = CNT_W'(IDLE_CYCLES - 1);
        // A pending wake blocks power-down and restarts the idle window.
        if (wake_req) begin
          w_clr = 1'b1;
        end else if (sw_pd_req) begin
          w_state_d = StQuiesce;
        end else if (w_idle) begin
          if (w_hit) w_state_d = StQuiesce;
        end else begin
          w_clr = 1'b1;
        end
      end
      StQuiesce: begin
        w_term = CNT_W'(ACK_TIMEOUT - 1);
        if (quiesce_ack) begin
          w_state_d = StDownSeq;
        end else if (wake_req) begin
          w_state_d = StRun;
        end else if (w_hit) begin
          w_state_d = StRun;
          w_abort   = 1'b1;
        end
      end
      StDownSeq: begin
        w_term = CNT_W'(SEQ_CYCLES - 1);
        if (w_hit) w_state_d = StOff;
      end
      StOff: begin
        // Counter saturates, so a wake held past the minimum is still honoured.
        w_term = CNT_W'(MIN_OFF - 1);
        if (w_hit && wake_req) w_state_d = StUpSeq;
      end
      StUpSeq: begin
        w_term = CNT_W'(SEQ_CYCLES - 1);
        if (w_hit) w_state_d = StRun;
      end
      default: w_state_d = StRun;
    endcase
    if (w_state_d != r_state) w_clr = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= StRun;
      r_pwr_sig     <= 1'b0;
      r_quiesce_req <= 1'b0;
      r_domain_off  <= 1'b0;
      r_domain_on   <= 1'b1;
      r_abort       <= 1'b0;
    end else begin
      r_state       <= w_state_d;
      r_pwr_sig     <= (w_state_d == StDownSeq) || (w_state_d == StOff);
      r_quiesce_req <= (w_state_d != StRun);
      r_domain_off  <= (w_state_d == StOff);
      r_domain_on   <= (w_state_d == StRun);
      r_abort       <= w_abort;
    end
  end

  assign pwr_sig     = r_pwr_sig;
  assign quiesce_req = r_quiesce_req;
  assign domain_off  = r_domain_off;
  assign domain_on   = r_domain_on;
  assign abort       = r_abort;
  assign pd_state    = r_state;

endmodule

// File: tb/tb_pwr_req_ctrl.sv
// Directed bench for pwr_req_ctrl with default parameters.
module tb_pwr_req_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       pd_en;
  logic       busy;
  logic       sw_pd_req;
  logic       wake_req;
  logic       quiesce_ack;
  logic       pwr_sig;
  logic       quiesce_req;
  logic       domain_off;
  logic       domain_on;
  logic       abort;
  logic [2:0] pd_state;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [7:0] RUN = 8'd0, QUI = 8'd1, DSQ = 8'd2, OFF = 8'd3, USQ = 8'd4;

  always #5 clk = ~clk;

  pwr_req_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .pd_en       (pd_en),
    .busy        (busy),
    .sw_pd_req   (sw_pd_req),
    .wake_req    (wake_req),
    .quiesce_ack (quiesce_ack),
    .pwr_sig     (pwr_sig),
    .quiesce_req (quiesce_req),
    .domain_off  (domain_off),
    .domain_on   (domain_on),
    .abort       (abort),
    .pd_state    (pd_state)
  );

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; pd_en = 1'b1; busy = 1'b0; sw_pd_req = 1'b0;
    wake_req = 1'b0; quiesce_ack = 1'b0;
    tick(2);
    check("rst_state", 8'(pd_state), RUN);
    check("rst_pwr", 8'(pwr_sig), 8'd0);
    check("rst_qreq", 8'(quiesce_req), 8'd0);
    check("rst_on", 8'(domain_on), 8'd1);
    check("rst_off", 8'(domain_off), 8'd0);
    check("rst_abort", 8'(abort), 8'd0);
    reset = 1'b0;

    // Idle expiry from reset release
    tick(15);
    check("idle_e15_qreq", 8'(quiesce_req), 8'd0);
    tick(1);
    check("idle_e16_qreq", 8'(quiesce_req), 8'd1);
    check("idle_e16_state", 8'(pd_state), QUI);

    // No ack: timeout after 32 cycles
    tick(31);
    check("to_31_qreq", 8'(quiesce_req), 8'd1);
    check("to_31_abort", 8'(abort), 8'd0);
    tick(1);
    check("to_abort", 8'(abort), 8'd1);
    check("to_qreq", 8'(quiesce_req), 8'd0);
    check("to_state", 8'(pd_state), RUN);
    tick(1);
    check("to_abort_1cyc", 8'(abort), 8'd0);
    tick(14);
    check("re_idle_15_qreq", 8'(quiesce_req), 8'd0);
    tick(1);
    check("re_idle_16_qreq", 8'(quiesce_req), 8'd1);

    // Ack two cycles in, wake raised during DOWN_SEQ
    tick(1);
    quiesce_ack = 1'b1;
    tick(1);
    check("ack_pwr", 8'(pwr_sig), 8'd1);
    check("ack_state", 8'(pd_state), DSQ);
    check("ack_off", 8'(domain_off), 8'd0);
    quiesce_ack = 1'b0;
    wake_req = 1'b1;
    tick(2);
    check("dsq2_off", 8'(domain_off), 8'd0);
    tick(1);
    check("dsq3_off", 8'(domain_off), 8'd1);
    check("dsq3_state", 8'(pd_state), OFF);
    tick(7);
    check("off7_pwr", 8'(pwr_sig), 8'd1);
    check("off7_state", 8'(pd_state), OFF);
    tick(1);
    check("off8_pwr", 8'(pwr_sig), 8'd0);
    check("off8_state", 8'(pd_state), USQ);
    check("off8_qreq", 8'(quiesce_req), 8'd1);
    check("off8_off", 8'(domain_off), 8'd0);
    tick(2);
    check("usq2_on", 8'(domain_on), 8'd0);
    check("usq2_qreq", 8'(quiesce_req), 8'd1);
    tick(1);
    check("usq3_on", 8'(domain_on), 8'd1);
    check("usq3_qreq", 8'(quiesce_req), 8'd0);
    check("usq3_state", 8'(pd_state), RUN);
    wake_req = 1'b0;

    // Busy at idle cycle 10 restarts the count
    tick(9);
    busy = 1'b1;
    tick(1);
    busy = 1'b0;
    tick(15);
    check("busy_15_qreq", 8'(quiesce_req), 8'd0);
    tick(1);
    check("busy_16_qreq", 8'(quiesce_req), 8'd1);

    // Wake during QUIESCE returns to RUN without abort
    wake_req = 1'b1;
    tick(1);
    check("qwake_state", 8'(pd_state), RUN);
    check("qwake_qreq", 8'(quiesce_req), 8'd0);
    check("qwake_abort", 8'(abort), 8'd0);

    // sw_pd_req with wake in the same cycle: wake wins
    sw_pd_req = 1'b1;
    tick(1);
    check("swwake_state", 8'(pd_state), RUN);
    sw_pd_req = 1'b0;
    wake_req = 1'b0;
    pd_en = 1'b0;

    // Software power-down ignores pd_en; wake two cycles into OFF
    sw_pd_req = 1'b1;
    tick(1);
    check("sw_state", 8'(pd_state), QUI);
    sw_pd_req = 1'b0;
    quiesce_ack = 1'b1;
    tick(1);
    quiesce_ack = 1'b0;
    tick(3);
    check("sw_off", 8'(domain_off), 8'd1);
    tick(2);
    wake_req = 1'b1;
    tick(5);
    check("ow7_pwr", 8'(pwr_sig), 8'd1);
    tick(1);
    check("ow8_pwr", 8'(pwr_sig), 8'd0);
    tick(3);
    check("ow_on", 8'(domain_on), 8'd1);
    check("ow_qreq", 8'(quiesce_req), 8'd0);
    wake_req = 1'b0;

    // Ack and wake together in QUIESCE: ack wins; then reset while OFF
    sw_pd_req = 1'b1;
    tick(1);
    sw_pd_req = 1'b0;
    quiesce_ack = 1'b1;
    wake_req = 1'b1;
    tick(1);
    check("ackwake_state", 8'(pd_state), DSQ);
    quiesce_ack = 1'b0;
    wake_req = 1'b0;
    tick(3);
    check("pre_rst_state", 8'(pd_state), OFF);
    reset = 1'b1;
    tick(1);
    check("rstoff_pwr", 8'(pwr_sig), 8'd0);
    check("rstoff_qreq", 8'(quiesce_req), 8'd0);
    check("rstoff_state", 8'(pd_state), RUN);
    check("rstoff_off", 8'(domain_off), 8'd0);
    check("rstoff_on", 8'(domain_on), 8'd1);
    reset = 1'b0;
    tick(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
